seq_shifter: RTL and testbench

Multi-cycle shifter for the Simple RISC Machine datapath. It extends the single-step `shifter` (00 pass, 01 LSL-1, 10 LSR-1, 11 ASR-1) to shift amounts of 0–15 by applying that step once per clock. It sits beside the ALU B-operand path and uses a start/busy/done handshake so the controller FSM can stall while the shift completes.

---
 rtl/srm_pkg.sv | 14 +
 rtl/shifter.sv | 20 ++
 rtl/seq_shifter.sv | 81 ++++++++
 tb/tb_seq_shifter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/srm_pkg.sv
// Shared encodings for the Simple RISC Machine datapath: shifter ops and the
// sequential-shifter state machine.
package srm_pkg;
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_SHIFT = 2'd1,
    SEQ_DONE  = 2'd2
  } seq_state_e;
endpackage

// File: rtl/shifter.sv
// Single-step combinational shifter: pass, LSL-1, LSR-1 or ASR-1.
module shifter
  import srm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] in,
  input  logic [1:0]   shift,
  output logic [W-1:0] sout
);
  always_comb begin
    sout = in;
    case (shift)
      SH_LSL:  sout = {in[W-2:0], 1'b0};
      SH_LSR:  sout = {1'b0, in[W-1:1]};
      SH_ASR:  sout = {in[W-1], in[W-1:1]};
      default: sout = in;
    endcase
  end
endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: applies the single-step shifter once per clock for
// 0..2^AW-1 steps behind a start/busy/done handshake.
module seq_shifter
  import srm_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  in,
  input  logic [1:0]    shift,
  input  logic [AW-1:0] amount,
  output logic [W-1:0]  sout,
  output logic          busy,
  output logic          done
);
  seq_state_e    state_q, state_d;
  logic [W-1:0]  sout_q, sout_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  step;

  shifter #(.W(W)) u_step (
    .in   (sout_q),
    .shift(op_q),
    .sout (step)
  );

  always_comb begin
    state_d = state_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          sout_d  = in;
          op_d    = shift;
          cnt_d   = amount;
          state_d = (amount == '0 || shift == SH_NONE) ? SEQ_DONE : SEQ_SHIFT;
        end
      end
      SEQ_SHIFT: begin
        sout_d = step;
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) state_d = SEQ_DONE;
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
    // Outputs are registered from the next state so they stay pure state decodes.
    busy_d = (state_d != SEQ_IDLE);
    done_d = (state_d == SEQ_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      sout_q  <= '0;
      cnt_q   <= '0;
      op_q    <= SH_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: latency, results, busy window, ignored
// start while busy, and mid-shift reset.
module tb_seq_shifter;
  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] in;
  logic [1:0]  shift;
  logic [3:0]  amount;
  logic [15:0] sout;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  seq_shifter #(.W(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in),
    .shift (shift),
    .amount(amount),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation and checks latency, busy window and final result.
  task automatic do_op(input string tag, input logic [15:0] i, input logic [1:0] sh,
                       input logic [3:0] amt, input logic [15:0] exp_sout, input int exp_n);
    int lat;
    int busy_cyc;
    in = i; shift = sh; amount = amt; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_n);
    check({tag, "_sout"}, sout, exp_sout);
    check({tag, "_busy_done"}, busy, 1'b1);
    check({tag, "_busy_cyc"}, busy_cyc, exp_n);
    tick();
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_hold"}, sout, exp_sout);
  endtask

  initial begin
    int dones;
    int lat;
    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; in = 16'hFFFF; shift = 2'b01; amount = 4'd3;
    tick();
    tick();
    check("rst_sout", sout, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("rst_idle_sout", sout, 16'h0000);

    do_op("lsl4", 16'hF0CF, 2'b01, 4'd4, 16'h0CF0, 4);
    do_op("lsr4", 16'hF0CF, 2'b10, 4'd4, 16'h0F0C, 4);
    do_op("asr4", 16'hF0CF, 2'b11, 4'd4, 16'hFF0C, 4);
    do_op("lsl1", 16'hF0CF, 2'b01, 4'd1, 16'hE19E, 1);
    do_op("lsr1", 16'hF0CF, 2'b10, 4'd1, 16'h7867, 1);
    do_op("asr1", 16'hF0CF, 2'b11, 4'd1, 16'hF867, 1);
    do_op("asr15", 16'h8000, 2'b11, 4'd15, 16'hFFFF, 15);
    do_op("amt0", 16'hF0CF, 2'b01, 4'd0, 16'hF0CF, 0);
    do_op("pass9", 16'h1234, 2'b00, 4'd9, 16'h1234, 0);

    // start held high with changing operands throughout a 10-step shift.
    in = 16'h0001; shift = 2'b01; amount = 4'd10; start = 1'b1;
    tick();
    lat = 0;
    dones = 0;
    while (!done && lat < 40) begin
      in = 16'($urandom); shift = 2'($urandom); amount = 4'($urandom);
      tick();
      lat++;
    end
    if (done) dones++;
    check("busy_ign_lat", lat, 10);
    check("busy_ign_sout", sout, 16'h0400);
    in = 16'h0003; shift = 2'b10; amount = 4'd1;
    tick();
    if (done) dones++;
    check("busy_ign_one_done", dones, 1);
    check("busy_ign_idle", busy, 1'b0);
    check("busy_ign_hold", sout, 16'h0400);
    tick();
    start = 1'b0;
    check("next_acc_busy", busy, 1'b1);
    tick();
    check("next_acc_done", done, 1'b1);
    check("next_acc_sout", sout, 16'h0001);
    tick();

    // Reset after three steps of an 8-step shift.
    in = 16'h00FF; shift = 2'b01; amount = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mid_sout_step3", sout, 16'h07F8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_sout", sout, 16'h0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done || busy) dones++;
    end
    check("mid_rst_quiet", dones, 0);
    do_op("after_rst", 16'h00FF, 2'b10, 4'd4, 16'h000F, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
